// File: rtl/uart8_cpu_jtag_ocimem_ctrl.sv
// rtl/uart8_cpu_jtag_ocimem_ctrl.sv - debug monitor RAM, MonAReg/MonDReg and monitor flags
// JTAG pulses are latched as pending requests and arbitrated against a CPU Avalon-MM slave.
module uart8_cpu_jtag_ocimem_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int INIT_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;

  state_t            state_q, state_d;
  logic              pa_q, pa_d, pn_q, pn_d, pb_q, pb_d;
  logic              rdy_q, rdy_d, err_q, err_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d, mon_a_inc, jtag_addr, cpu_addr;
  logic [31:0]       mon_d_q, mon_d_d, jrd_q, jrd_d, rdata_q, rdata_d;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              pulse_any, cpu_ok, cpu_flag, wr_done;
  logic              unused_jdo;

  assign jtag_addr  = jdo[ADDR_W+1:2];
  assign mon_a_inc  = mon_a_q + ADDR_W'(1);
  assign cpu_addr   = avs_address[ADDR_W-1:0];
  assign cpu_flag   = avs_address[ADDR_W];
  assign pulse_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // The CPU only gets the RAM when no JTAG work is pending or arriving this cycle.
  assign cpu_ok     = reset_n && (state_q == IDLE) && !(pa_q || pn_q || pb_q) && !pulse_any;
  assign wr_done    = cpu_ok && avs_write && !avs_read;
  assign avs_waitrequest = !(reset_n && (wr_done || (state_q == CRD)));
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign avs_readdata  = rdata_q;
  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

  always_comb begin
    state_d   = state_q;
    pa_d      = pa_q | take_action_ocimem_a;
    pn_d      = pn_q | take_no_action_ocimem_a;
    pb_d      = pb_q | take_action_ocimem_b;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    jrd_d     = jrd_q;
    rdata_d   = rdata_q;
    rdy_d     = rdy_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = mon_a_q;
    mem_wdata = jdo[34:3];
    case (state_q)
      IDLE: begin
        if (pa_q) begin
          pa_d    = take_action_ocimem_a;
          mon_a_d = jtag_addr;
          rdy_d   = 1'b0;
          err_d   = 1'b0;
          if (jdo[35]) begin
            jrd_d   = mem[jtag_addr];
            state_d = JRD;
          end
        end else if (pn_q) begin
          pn_d    = take_no_action_ocimem_a;
          mon_a_d = mon_a_inc;
          jrd_d   = mem[mon_a_inc];
          state_d = JRD;
        end else if (pb_q) begin
          pb_d    = take_action_ocimem_b;
          mem_we  = 1'b1;
          mon_a_d = mon_a_inc;
        end else if (cpu_ok && avs_read) begin
          rdata_d = cpu_flag ? {30'b0, err_q, rdy_q} : mem[cpu_addr];
          state_d = CRD;
        end else if (wr_done) begin
          if (cpu_flag) begin
            rdy_d = avs_writedata[0];
            err_d = avs_writedata[1];
          end else begin
            mem_we    = 1'b1;
            mem_waddr = cpu_addr;
            mem_wdata = avs_writedata;
          end
        end
      end
      JRD: begin
        mon_d_d = jrd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pa_q    <= 1'b0;
      pn_q    <= 1'b0;
      pb_q    <= 1'b0;
      mon_a_q <= ADDR_W'(INIT_ADDR);
      mon_d_q <= '0;
      jrd_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pa_q    <= pa_d;
      pn_q    <= pn_d;
      pb_q    <= pb_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      jrd_q   <= jrd_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
endmodule
